// File: rtl/hilo_div_ctrl.sv
// HI/LO owner and divide sequencer: one-cycle MULT/MULTU/MTHI/MTLO, handshaked signed/unsigned DIV.
// Optional HILO_BYPASS_EN forwards the value being written to hi_out/lo_out in the same cycle.
module hilo_div_ctrl #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_start,
    input  logic             div_busy,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             stall
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    state_e           state_q, state_d;
    logic             wait_first_q, wait_first_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic               is_sdiv;

    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
    assign prod_s = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};

    assign is_sdiv = (op == OpDiv);
    assign rs_mag  = (is_sdiv && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag  = (is_sdiv && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    always_comb begin
        state_d      = state_q;
        wait_first_d = wait_first_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        div_start    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    case (op)
                        OpMult:  {hi_d, lo_d} = prod_s;
                        OpMultu: {hi_d, lo_d} = prod_u;
                        OpMthi:  hi_d = rs_val;
                        OpMtlo:  lo_d = rs_val;
                        OpDiv, OpDivu: begin
                            if (rt_val == '0) begin
                                hi_d = rs_val;
                                lo_d = DIV0_LO;
                            end else begin
                                dividend_d = rs_mag;
                                divisor_d  = rt_mag;
                                qneg_d     = is_sdiv && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                rneg_d     = is_sdiv && rs_val[WIDTH-1];
                                state_d    = StStart;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StStart: begin
                div_start    = 1'b1;
                wait_first_d = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                // Busy is not yet valid in the first WAIT cycle.
                wait_first_d = 1'b0;
                if (!wait_first_q && !div_busy) begin
                    lo_d    = qneg_q ? -div_q : div_q;
                    hi_d    = rneg_q ? -div_r : div_r;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            wait_first_q <= 1'b0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_first_q <= wait_first_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
        end
    end

    assign stall        = (state_q != StIdle);
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

`ifdef HILO_BYPASS_EN
    assign hi_out = hi_d;
    assign lo_out = lo_d;
`else
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural 33-cycle divider and HI/LO reference model.
module tb_hilo_div_ctrl;

    localparam int BusyLen = 33;
    localparam int DivStallCycles = BusyLen + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic [31:0] div_dividend, div_divisor;
    logic        div_start;
    logic        div_busy;
    logic [31:0] div_q, div_r;
    logic [31:0] hi_out, lo_out;
    logic        stall;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    hilo_div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_busy     (div_busy),
        .div_q        (div_q),
        .div_r        (div_r),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .stall        (stall)
    );

    // Behavioural divider: result latched on start, busy for BusyLen cycles afterwards.
    int busy_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
            div_q    <= '0;
            div_r    <= '0;
        end else if (div_start) begin
            busy_cnt <= BusyLen;
            div_q    <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            div_r    <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign div_busy = (busy_cnt != 0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt);
        longint      a, b;
        logic [63:0] p;
        case (o)
            3'd1: begin
                a = $signed(rs);
                b = $signed(rt);
                p = a * b;
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd2: begin
                p = {32'd0, rs} * {32'd0, rt};
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd3, 3'd4: begin
                if (rt == 0) begin
                    hi_m = rs;
                    lo_m = 32'hFFFF_FFFF;
                end else if (o == 3'd3) begin
                    a = $signed(rs);
                    b = $signed(rt);
                    p = a / b;
                    lo_m = p[31:0];
                    p = a % b;
                    hi_m = p[31:0];
                end else begin
                    lo_m = rs / rt;
                    hi_m = rs % rt;
                end
            end
            3'd5: hi_m = rs;
            3'd6: lo_m = rs;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] mag(input logic [2:0] o, input logic [31:0] v);
        longint x;
        if (o != 3'd3) return v;
        x = $signed(v);
        if (x < 0) x = -x;
        return x[31:0];
    endfunction

    // Issues one op and follows it until stall drops; reports start pulses and stalled cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                          output int starts, output int stall_cycles, output bit timeout);
        op_valid = 1'b1;
        op       = o;
        rs_val   = rs;
        rt_val   = rt;
        tick();
        op_valid = 1'b0;
        op       = 3'd0;
        starts   = 0;
        stall_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!stall) break;
            stall_cycles++;
            if (div_start) starts++;
            tick();
        end
        timeout = stall;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        op_valid = 1'b0;
        op = 3'd0;
        rs_val = '0;
        rt_val = '0;
        tick();
        n_checks++;
        if ({hi_out, lo_out, div_dividend, div_divisor, div_start, stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: hi=%h lo=%h dvd=%h dvs=%h start=%b stall=%b, required all 0",
                     hi_out, lo_out, div_dividend, div_divisor, div_start, stall);
        end
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        tick();
    endtask

    task automatic test_mult;
        logic [2:0] ops [2] = '{3'd1, 3'd2};
        for (int k = 0; k < 2; k++) begin
            op_valid = 1'b1;
            op = ops[k];
            rs_val = 32'hFFFF_FFFE;
            rt_val = 32'd3;
            #1;
            n_checks++;
            if (stall !== 1'b0 || div_start !== 1'b0) begin
                n_fail++;
                $display("FAIL mult_accept_nostall op=%0d: stall=%b start=%b, required 0 0",
                         ops[k], stall, div_start);
            end
            tick();
            op_valid = 1'b0;
            model_op(ops[k], 32'hFFFF_FFFE, 32'd3);
            n_checks++;
            if (hi_out !== hi_m || lo_out !== lo_m || stall !== 1'b0 || div_start !== 1'b0) begin
                n_fail++;
                $display("FAIL mult_result op=%0d: hi=%h lo=%h stall=%b start=%b, required hi=%h lo=%h 0 0",
                         ops[k], hi_out, lo_out, stall, div_start, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_mtx;
        logic [31:0] v;
        logic [31:0] seen, same_cycle;
        for (int k = 0; k < 2; k++) begin
            v = $urandom;
            op_valid = 1'b1;
            op = (k == 0) ? 3'd5 : 3'd6;
            rs_val = v;
            #1;
            seen = (k == 0) ? hi_out : lo_out;
`ifdef HILO_BYPASS_EN
            same_cycle = v;
`else
            same_cycle = (k == 0) ? hi_m : lo_m;
`endif
            n_checks++;
            if (seen !== same_cycle) begin
                n_fail++;
                $display("FAIL mtx_same_cycle k=%0d: got %h, required %h", k, seen, same_cycle);
            end
            tick();
            op_valid = 1'b0;
            model_op(op, v, 32'd0);
            n_checks++;
            if (hi_out !== hi_m || lo_out !== lo_m) begin
                n_fail++;
                $display("FAIL mtx_result k=%0d: hi=%h lo=%h, required hi=%h lo=%h",
                         k, hi_out, lo_out, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_div_fixed;
        logic [2:0]  ops [4] = '{3'd3, 3'd4, 3'd3, 3'd3};
        logic [31:0] rss [4] = '{32'd8, 32'd8, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] rts [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFF};
        int starts, sc;
        bit to;
        for (int k = 0; k < 4; k++) begin
            run_op(ops[k], rss[k], rts[k], starts, sc, to);
            model_op(ops[k], rss[k], rts[k]);
            n_checks++;
            if (to || starts != 1 || sc != DivStallCycles) begin
                n_fail++;
                $display("FAIL div_handshake k=%0d: timeout=%0d starts=%0d stall_cycles=%0d, required 0 1 %0d",
                         k, to, starts, sc, DivStallCycles);
            end
            n_checks++;
            if (div_dividend !== mag(ops[k], rss[k]) || div_divisor !== mag(ops[k], rts[k])) begin
                n_fail++;
                $display("FAIL div_operands k=%0d: dvd=%h dvs=%h, required %h %h", k,
                         div_dividend, div_divisor, mag(ops[k], rss[k]), mag(ops[k], rts[k]));
            end
            n_checks++;
            if (hi_out !== hi_m || lo_out !== lo_m) begin
                n_fail++;
                $display("FAIL div_result k=%0d: hi=%h lo=%h, required hi=%h lo=%h",
                         k, hi_out, lo_out, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_div_zero;
        int starts, sc;
        bit to;
        for (int k = 0; k < 2; k++) begin
            run_op((k == 0) ? 3'd3 : 3'd4, 32'h1234_5678 + k, 32'd0, starts, sc, to);
            model_op((k == 0) ? 3'd3 : 3'd4, 32'h1234_5678 + k, 32'd0);
            n_checks++;
            if (starts != 0 || sc != 0 || hi_out !== hi_m || lo_out !== lo_m) begin
                n_fail++;
                $display("FAIL div_by_zero k=%0d: starts=%0d stall_cycles=%0d hi=%h lo=%h, required 0 0 hi=%h lo=%h",
                         k, starts, sc, hi_out, lo_out, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] rs, rt;
        int starts, sc, exp_starts, exp_sc;
        bit to;
        for (int k = 0; k < 40; k++) begin
            o  = 3'($urandom_range(0, 7));
            rs = $urandom;
            case ($urandom_range(0, 7))
                0:       rt = 32'd0;
                1:       rt = 32'($urandom_range(1, 9));
                2:       rt = -32'($urandom_range(1, 9));
                default: rt = $urandom;
            endcase
            run_op(o, rs, rt, starts, sc, to);
            model_op(o, rs, rt);
            exp_starts = ((o == 3'd3 || o == 3'd4) && rt != 0) ? 1 : 0;
            exp_sc     = exp_starts * DivStallCycles;
            n_checks++;
            if (to || starts != exp_starts || sc != exp_sc) begin
                n_fail++;
                $display("FAIL rand_handshake k=%0d op=%0d: starts=%0d stall_cycles=%0d, required %0d %0d",
                         k, o, starts, sc, exp_starts, exp_sc);
            end
            n_checks++;
            if (hi_out !== hi_m || lo_out !== lo_m) begin
                n_fail++;
                $display("FAIL rand_result k=%0d op=%0d rs=%h rt=%h: hi=%h lo=%h, required hi=%h lo=%h",
                         k, o, rs, rt, hi_out, lo_out, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_ignore_during_wait;
        bit done = 1'b0;
        op_valid = 1'b1;
        op = 3'd4;
        rs_val = 32'd1000;
        rt_val = 32'd7;
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        op_valid = 1'b1;
        op = 3'd6;
        rs_val = 32'h55;
        #1;
        n_checks++;
        if (stall !== 1'b1 || lo_out !== lo_m || hi_out !== hi_m) begin
            n_fail++;
            $display("FAIL wait_holds_old: stall=%b hi=%h lo=%h, required 1 hi=%h lo=%h",
                     stall, hi_out, lo_out, hi_m, lo_m);
        end
        tick();
        op_valid = 1'b0;
        op = 3'd0;
        for (int i = 0; i < 100; i++) begin
            if (!stall) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        model_op(3'd4, 32'd1000, 32'd7);
        n_checks++;
        if (!done || lo_out !== lo_m || hi_out !== hi_m) begin
            n_fail++;
            $display("FAIL wait_ignores_op: done=%0d hi=%h lo=%h, required 1 hi=%h lo=%h",
                     done, hi_out, lo_out, hi_m, lo_m);
        end
    endtask

    task automatic test_reset_mid_div;
        logic [31:0] same_cycle;
        op_valid = 1'b1;
        op = 3'd3;
        rs_val = 32'd100;
        rt_val = 32'd7;
        tick();
        op_valid = 1'b0;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        #1;
        hi_m = '0;
        lo_m = '0;
        n_checks++;
        if (stall !== 1'b0 || div_start !== 1'b0 || hi_out !== '0 || lo_out !== '0 ||
            div_dividend !== '0 || div_divisor !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_div: stall=%b start=%b hi=%h lo=%h dvd=%h dvs=%h, required all 0",
                     stall, div_start, hi_out, lo_out, div_dividend, div_divisor);
        end
        tick();
        rst = 1'b0;
        tick();
        op_valid = 1'b1;
        op = 3'd5;
        rs_val = 32'hA5A5_A5A5;
        #1;
`ifdef HILO_BYPASS_EN
        same_cycle = 32'hA5A5_A5A5;
`else
        same_cycle = 32'h0;
`endif
        n_checks++;
        if (hi_out !== same_cycle || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_mthi_same_cycle: hi=%h stall=%b, required %h 0",
                     hi_out, stall, same_cycle);
        end
        tick();
        op_valid = 1'b0;
        model_op(3'd5, 32'hA5A5_A5A5, 32'd0);
        n_checks++;
        if (hi_out !== hi_m || lo_out !== lo_m) begin
            n_fail++;
            $display("FAIL post_reset_mthi: hi=%h lo=%h, required hi=%h lo=%h",
                     hi_out, lo_out, hi_m, lo_m);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mtx();
        test_div_fixed();
        test_div_zero();
        test_random();
        test_ignore_during_wait();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Sits in EX between the decoded multiply/divide ops and the iterative unsigned divider core. It also owns the architectural HI/LO registers.
- DIV/DIVU: converts operands to magnitudes, sequences the divider's start/busy handshake, applies sign fix-up, then writes quotient to LO and remainder to HI.
- MULT/MULTU/MTHI/MTLO: completes in one cycle.
- Drives the pipeline stall while a divide is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  op present in EX this cycle.
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NOP).
- rs_val  in  WIDTH  dividend / multiplicand / MTHI-MTLO source.
- rt_val  in  WIDTH  divisor / multiplier.
- div_dividend  out  WIDTH  unsigned magnitude to divider core, registered.
- div_divisor  out  WIDTH  unsigned magnitude to divider core, registered.
- div_start  out  1  single-cycle start pulse to divider.
- div_busy  in  1  divider busy.
- div_q  in  WIDTH  divider unsigned quotient.
- div_r  in  WIDTH  divider unsigned remainder.
- hi_out  out  WIDTH  HI for MFHI.
- lo_out  out  WIDTH  LO for MFLO.
- stall  out  1  high while a divide is in flight.

Behaviour:
- Reset (async, any state, including mid-divide):
  - state=IDLE.
  - HI=0, LO=0, div_start=0, div_dividend=0, div_divisor=0, sign flags cleared.
- States: IDLE, START, WAIT.
- stall = (state != IDLE), combinational. The accepting cycle itself is not stalled.
- An op is accepted only when op_valid=1 and state=IDLE. In START/WAIT, op_valid is ignored; the upstream pipeline holds under stall.
- MULT (signed) / MULTU (unsigned): {HI,LO} <= full 64-bit product at the accept edge.
- MTHI: HI <= rs_val. MTLO: LO <= rs_val. Both at the accept edge.
- DIV/DIVU with rt_val==0:
  - No divider handshake.
  - HI <= rs_val, LO <= DIV0_LO at the accept edge; state stays IDLE.
- DIV/DIVU with rt_val!=0, accept edge:
  - div_dividend/div_divisor <= |rs_val|/|rt_val| for DIV, raw values for DIVU.
  - Latch qneg = rs[31]^rt[31] and rneg = rs[31] (DIV only, else 0).
  - state -> START.
- START: div_start=1 for exactly this cycle; -> WAIT.
- WAIT:
  - The first WAIT cycle is ignored; the divider raises busy the cycle after sampling start.
  - Thereafter, at the first cycle with div_busy=0, capture at the edge: LO <= qneg ? -div_q : div_q, HI <= rneg ? -div_r : div_r; -> IDLE.
- Minimum DIV latency = accept + 2 cycles + divider busy length.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of magnitude arithmetic and needs no special case.
- hi_out/lo_out reflect registered HI/LO. During WAIT they still show the pre-divide values.
- div_dividend/div_divisor hold their values until the next accepted divide.

Optional Feature:
- Macro HILO_BYPASS_EN.
- Defined: hi_out/lo_out combinationally forward the value being written this cycle, so MFHI/MFLO see it with zero latency. Applies to:
  - MTHI/MTLO/MULT/MULTU/div-by-zero at the accept edge.
  - The DIV capture edge in WAIT.
- Undefined: hi_out/lo_out are purely registered; the new value appears the cycle after the write.

Test Plan:
- Divider model for the bench: behavioural unsigned divider, busy high 33 cycles after start.
- DIV rs=8, rt=0xFFFFFFFD -> div_dividend=8, div_divisor=3, div_start one pulse; after busy falls LO=0xFFFFFFFE, HI=0x00000002; stall high from accept+1 through the capture cycle.
- DIVU rs=8, rt=0xFFFFFFFD -> LO=0, HI=8. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULT rs=0xFFFFFFFE, rt=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA next cycle. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA. Neither ever raises stall or div_start.
- DIV rs=0x12345678, rt=0 -> no div_start, stall stays 0, HI=0x12345678, LO=0xFFFFFFFF.
- Start DIV 100/7, assert rst 10 cycles into WAIT -> immediately state IDLE, stall=0, HI=LO=0, div_start=0. Then MTHI 0xA5A5A5A5 -> hi_out=0xA5A5A5A5 (same cycle with HILO_BYPASS_EN, next cycle without).
- Pulse op_valid with MTLO 0x55 during WAIT -> ignored, LO ends as the divide quotient.
